noc_vc_input_buffer: RTL and testbench

//  Router input port: parametrised multi-VC flit buffer with credit-based flow control.

---
 rtl/noc_config_pkg.sv | 27 ++
 rtl/noc_vc_fifo.sv | 54 +++++
 rtl/noc_vc_input_buffer.sv | 149 ++++++++++++++
 tb/tb_noc_vc_input_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_config_pkg.sv
// Shared NoC router configuration: default geometry, flit type encoding and
// the wormhole lock state used by the input buffer.
package noc_config_pkg;

  localparam int FLIT_WIDTH    = 128;
  localparam int VC_COUNT      = 3;
  localparam int BUFFER_DEPTH  = 4;
  localparam int FLIT_TYPE_MSB = FLIT_WIDTH - 1;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index width that stays at least one bit wide for single-entry sets.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Per-VC synchronous FIFO: head is the oldest stored flit, count is the fill level.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module noc_vc_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Router input port: per-VC flit FIFOs, credit return, round-robin VC selection
// and an optional wormhole lock that keeps a VC selected until its tail leaves.
module noc_vc_input_buffer
  import noc_config_pkg::*;
#(
  parameter int  FLIT_WIDTH   = noc_config_pkg::FLIT_WIDTH,
  parameter int  VC_COUNT     = noc_config_pkg::VC_COUNT,
  parameter int  BUFFER_DEPTH = noc_config_pkg::BUFFER_DEPTH,
  parameter bit  PKT_LOCK     = 1'b1,
  localparam int VCW          = noc_config_pkg::idx_width(VC_COUNT),
  localparam int CW           = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [VCW-1:0]           in_vc,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  output logic                     credit_valid,
  output logic [VCW-1:0]           credit_vc,
  output logic                     out_valid,
  output logic [VCW-1:0]           out_vc,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  input  logic                     out_ready,
  output logic [VC_COUNT*CW-1:0]   vc_occupancy,
  output logic                     err_overflow
);

  logic [VC_COUNT-1:0]   push;
  logic [VC_COUNT-1:0]   pop;
  logic [VC_COUNT-1:0]   full;
  logic [VC_COUNT-1:0]   empty;
  logic [FLIT_WIDTH-1:0] head [VC_COUNT];
  logic [CW-1:0]         count [VC_COUNT];

  lock_state_e    state_q, state_d;
  logic [VCW-1:0] lock_vc_q, lock_vc_d;
  logic [VCW-1:0] rr_q, rr_d;
  logic [VCW-1:0] rr_pick;
  logic [VCW-1:0] sel_vc;
  logic [VCW-1:0] next_vc;
  logic           rr_found;
  logic           sel_valid;
  logic           do_pop;
  logic           in_vc_ok;
  logic           drop;
  flit_type_e     pop_type;

  assign in_vc_ok = (int'(in_vc) < VC_COUNT);
  // A flit that no FIFO accepted is lost: bad VC, or full VC without a same-cycle pop.
  assign drop     = in_valid && (push == '0);

  for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
    assign push[v] = in_valid && in_vc_ok && (int'(in_vc) == v) && (!full[v] || pop[v]);
    assign pop[v]  = do_pop && (int'(sel_vc) == v);
    assign vc_occupancy[v*CW +: CW] = count[v];

    noc_vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (in_flit),
      .head  (head[v]),
      .count (count[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = 0;
    for (int i = 0; i < VC_COUNT; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= VC_COUNT) idx = idx - VC_COUNT;
      if (!rr_found && !empty[idx]) begin
        rr_found = 1'b1;
        rr_pick  = VCW'(idx);
      end
    end
  end

  // A held lock stalls the port while the locked VC is empty rather than interleaving.
  always_comb begin
    if (PKT_LOCK && (state_q == LOCK_HELD)) begin
      sel_vc    = lock_vc_q;
      sel_valid = !empty[lock_vc_q];
    end else begin
      sel_vc    = rr_pick;
      sel_valid = rr_found;
    end
  end

  assign out_valid = sel_valid;
  assign out_vc    = sel_valid ? sel_vc : '0;
  assign out_flit  = sel_valid ? head[sel_vc] : '0;
  assign do_pop    = sel_valid && out_ready;
  assign pop_type  = flit_type_e'(out_flit[FLIT_WIDTH-1 -: 2]);
  assign next_vc   = (int'(sel_vc) == VC_COUNT - 1) ? '0 : sel_vc + VCW'(1);

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    if (do_pop) begin
      if (PKT_LOCK) begin
        case (pop_type)
          FLIT_HEAD: begin
            state_d   = LOCK_HELD;
            lock_vc_d = sel_vc;
          end
          FLIT_TAIL, FLIT_SINGLE: begin
            state_d = LOCK_IDLE;
            rr_d    = next_vc;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end else begin
        rr_d = next_vc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOCK_IDLE;
      lock_vc_q    <= '0;
      rr_q         <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      err_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_vc_q    <= lock_vc_d;
      rr_q         <= rr_d;
      credit_valid <= do_pop;
      credit_vc    <= do_pop ? sel_vc : '0;
      if (drop) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer: one locked and one unlocked instance
// share the input side; each scenario task checks its own expected values.
module tb_noc_vc_input_buffer;
  import noc_config_pkg::*;

  localparam int FW = 128;
  localparam int OW = 9;

  // Clock / reset / shared stimulus
  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_vc    = '0;
  logic [FW-1:0] in_flit  = '0;
  logic          ready_l  = 1'b0;
  logic          ready_u  = 1'b0;

  logic          cv_l, ov_l, err_l, cv_u, ov_u, err_u;
  logic [1:0]    cvc_l, ovc_l, cvc_u, ovc_u;
  logic [FW-1:0] of_l, of_u;
  logic [OW-1:0] occ_l, occ_u;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_vc_input_buffer #(.FLIT_WIDTH(FW), .VC_COUNT(3), .BUFFER_DEPTH(4), .PKT_LOCK(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .credit_valid(cv_l), .credit_vc(cvc_l), .out_valid(ov_l), .out_vc(ovc_l),
    .out_flit(of_l), .out_ready(ready_l), .vc_occupancy(occ_l), .err_overflow(err_l)
  );

  noc_vc_input_buffer #(.FLIT_WIDTH(FW), .VC_COUNT(3), .BUFFER_DEPTH(4), .PKT_LOCK(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .credit_valid(cv_u), .credit_vc(cvc_u), .out_valid(ov_u), .out_vc(ovc_u),
    .out_flit(of_u), .out_ready(ready_u), .vc_occupancy(occ_u), .err_overflow(err_u)
  );

  function automatic logic [FW-1:0] mk(input flit_type_e t, input logic [15:0] p);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 2] = t;
    f[15:0] = p;
    return f;
  endfunction

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] vc, input logic [FW-1:0] f);
    in_valid = 1'b1;
    in_vc    = vc;
    in_flit  = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; ready_l = 1'b0; ready_u = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    total++; if ({cv_l, cvc_l, cv_u, cvc_u} !== 6'd0) begin bad++; $display("FAIL reset_credit: got %0h want 0", {cv_l, cvc_l, cv_u, cvc_u}); end
    total++; if ({ov_l, ovc_l, of_l} !== '0) begin bad++; $display("FAIL reset_out: got %0h want 0", {ov_l, ovc_l, of_l}); end
    total++; if ({occ_l, err_l, err_u} !== '0) begin bad++; $display("FAIL reset_occ_err: got %0h want 0", {occ_l, err_l, err_u}); end
    rst_n = 1'b1;
    tick();
    push(2'd0, mk(FLIT_HEAD, 16'h0001));
    push(2'd1, mk(FLIT_BODY, 16'h0002));
    total++; if (occ_l !== 9'd9) begin bad++; $display("FAIL reset_pre_occ: got %0h want 9", occ_l); end
    ready_l = 1'b1; ready_u = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ov_l, ovc_l, of_l} !== '0) begin bad++; $display("FAIL reset_mid_out: got %0h want 0", {ov_l, ovc_l, of_l}); end
    total++; if ({occ_l, occ_u} !== '0) begin bad++; $display("FAIL reset_mid_occ: got %0h want 0", {occ_l, occ_u}); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({cv_l, cv_u, ov_l, ov_u} !== 4'd0) begin bad++; $display("FAIL reset_no_credit: got %0h want 0", {cv_l, cv_u, ov_l, ov_u}); end
    end
    ready_l = 1'b0; ready_u = 1'b0;
  endtask

  task automatic test_single();
    logic [FW-1:0] fs;
    do_reset();
    fs = mk(FLIT_SINGLE, 16'h0011);
    in_valid = 1'b1; in_vc = 2'd1; in_flit = fs;
    ready_l = 1'b1; ready_u = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if ({ov_l, ovc_l} !== 3'b1_01) begin bad++; $display("FAIL single_out: got %0h want 5", {ov_l, ovc_l}); end
    total++; if (of_l !== fs) begin bad++; $display("FAIL single_flit: got %0h want %0h", of_l, fs); end
    total++; if (cv_l !== 1'b0) begin bad++; $display("FAIL single_early_credit: got %0h want 0", cv_l); end
    tick();
    total++; if ({cv_l, cvc_l} !== 3'b1_01) begin bad++; $display("FAIL single_credit: got %0h want 5", {cv_l, cvc_l}); end
    total++; if ({cv_u, cvc_u} !== 3'b1_01) begin bad++; $display("FAIL single_credit_u: got %0h want 5", {cv_u, cvc_u}); end
    total++; if ({ov_l, occ_l} !== '0) begin bad++; $display("FAIL single_drained: got %0h want 0", {ov_l, occ_l}); end
    tick();
    total++; if ({cv_l, cvc_l} !== 3'd0) begin bad++; $display("FAIL single_credit_end: got %0h want 0", {cv_l, cvc_l}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, mk(FLIT_BODY, 16'(16 + i)));
    total++; if ({occ_l, err_l} !== {9'd4, 1'b0}) begin bad++; $display("FAIL ovf_fill: got %0h want 8", {occ_l, err_l}); end
    push(2'd0, mk(FLIT_BODY, 16'h0099));
    total++; if (err_l !== 1'b1) begin bad++; $display("FAIL ovf_err: got %0h want 1", err_l); end
    total++; if (occ_l !== 9'd4) begin bad++; $display("FAIL ovf_occ: got %0h want 4", occ_l); end
    tick();
    total++; if (err_l !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0h want 1", err_l); end
    ready_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({ov_l, of_l} !== {1'b1, mk(FLIT_BODY, 16'(16 + i))}) begin bad++; $display("FAIL ovf_drain%0d: got %0h want %0h", i, of_l, mk(FLIT_BODY, 16'(16 + i))); end
      tick();
    end
    total++; if ({ov_l, occ_l, err_l, err_u} !== {1'b0, 9'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL ovf_end: got %0h want 3", {ov_l, occ_l, err_l, err_u}); end
    ready_l = 1'b0;
  endtask

  task automatic test_order();
    logic [FW-1:0] h, b, t, s;
    logic [FW-1:0] exp_lf [4];
    logic [FW-1:0] exp_uf [4];
    logic [1:0]    exp_lv [4];
    logic [1:0]    exp_uv [4];
    do_reset();
    h = mk(FLIT_HEAD, 16'h0010); b = mk(FLIT_BODY, 16'h0011);
    t = mk(FLIT_TAIL, 16'h0012); s = mk(FLIT_SINGLE, 16'h0013);
    exp_lf = '{h, b, t, s}; exp_lv = '{2'd0, 2'd0, 2'd0, 2'd2};
    exp_uf = '{h, s, b, t}; exp_uv = '{2'd0, 2'd2, 2'd0, 2'd0};
    push(2'd0, h); push(2'd0, b); push(2'd0, t); push(2'd2, s);
    ready_l = 1'b1; ready_u = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({ov_l, ovc_l, of_l} !== {1'b1, exp_lv[i], exp_lf[i]}) begin bad++; $display("FAIL lock_order%0d: got vc=%0d %0h want vc=%0d %0h", i, ovc_l, of_l, exp_lv[i], exp_lf[i]); end
      total++; if ({ov_u, ovc_u, of_u} !== {1'b1, exp_uv[i], exp_uf[i]}) begin bad++; $display("FAIL nolock_order%0d: got vc=%0d %0h want vc=%0d %0h", i, ovc_u, of_u, exp_uv[i], exp_uf[i]); end
      tick();
    end
    total++; if ({ov_l, ov_u} !== 2'b00) begin bad++; $display("FAIL order_end: got %0h want 0", {ov_l, ov_u}); end
    ready_l = 1'b0; ready_u = 1'b0;
  endtask

  task automatic test_lock_hold();
    logic [FW-1:0] h, t, s;
    do_reset();
    h = mk(FLIT_HEAD, 16'h0020); t = mk(FLIT_TAIL, 16'h0021); s = mk(FLIT_SINGLE, 16'h0022);
    push(2'd0, h); push(2'd2, s);
    ready_l = 1'b1;
    total++; if ({ovc_l, of_l} !== {2'd0, h}) begin bad++; $display("FAIL hold_head: got vc=%0d %0h want vc=0 %0h", ovc_l, of_l, h); end
    tick();
    total++; if ({ov_l, ovc_l} !== 3'd0) begin bad++; $display("FAIL hold_stall: got %0h want 0", {ov_l, ovc_l}); end
    total++; if (occ_l !== 9'b001_000_000) begin bad++; $display("FAIL hold_occ: got %0h want 40", occ_l); end
    push(2'd0, t);
    total++; if ({ov_l, ovc_l, of_l} !== {3'b1_00, t}) begin bad++; $display("FAIL hold_tail: got vc=%0d %0h want vc=0 %0h", ovc_l, of_l, t); end
    tick();
    total++; if ({ov_l, ovc_l, of_l} !== {3'b1_10, s}) begin bad++; $display("FAIL hold_release: got vc=%0d %0h want vc=2 %0h", ovc_l, of_l, s); end
    tick();
    total++; if (ov_l !== 1'b0) begin bad++; $display("FAIL hold_end: got %0h want 0", ov_l); end
    ready_l = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) f[i] = mk(FLIT_BODY, 16'(16'h0A0 + i));
    push(2'd1, f[0]);
    for (int i = 0; i < 3; i++) begin
      total++; if ({ov_l, of_l, cv_l} !== {1'b1, f[0], 1'b0}) begin bad++; $display("FAIL bp_stall%0d: got %0h want %0h", i, of_l, f[0]); end
      tick();
    end
    push(2'd1, f[1]); push(2'd1, f[2]); push(2'd1, f[3]);
    total++; if (occ_l !== 9'd32) begin bad++; $display("FAIL bp_full: got %0h want 20", occ_l); end
    in_valid = 1'b1; in_vc = 2'd1; in_flit = f[4];
    ready_l = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if ({occ_l, err_l} !== {9'd32, 1'b0}) begin bad++; $display("FAIL bp_enq_pop: got %0h want 40", {occ_l, err_l}); end
    total++; if ({cv_l, cvc_l} !== 3'b1_01) begin bad++; $display("FAIL bp_credit: got %0h want 5", {cv_l, cvc_l}); end
    for (int i = 1; i < 5; i++) begin
      total++; if ({ov_l, of_l} !== {1'b1, f[i]}) begin bad++; $display("FAIL bp_drain%0d: got %0h want %0h", i, of_l, f[i]); end
      tick();
    end
    total++; if ({ov_l, occ_l} !== '0) begin bad++; $display("FAIL bp_end: got %0h want 0", {ov_l, occ_l}); end
    ready_l = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    test_reset();
    test_single();
    test_overflow();
    test_order();
    test_lock_hold();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
